// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC register, instruction-ROM address drive and the
// IF/ID pipeline register. Next-PC sources by priority: interrupt, taken
// branch (EX), load-use stall, jump (ID), sequential PC+4.
// Optional feature: define FETCH_IRQ_EN to enable interrupt entry and EPC capture.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_W     = 9,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_jump,
  input  logic [31:0]       i_jump_target,
  input  logic              i_branch_taken,
  input  logic [31:0]       i_branch_target,
  input  logic              i_irq,
  output logic [ADDR_W-1:0] o_imem_address,
  input  logic [31:0]       i_imem_instruction,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_ifid_instruction,
  output logic [31:0]       o_ifid_pc_plus4,
  output logic              o_ifid_valid,
  output logic [31:0]       o_epc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic [31:0] norm_pc;
  logic        irq_take;
  logic        unused_bits;

  assign pc_plus4   = pc_q + 32'd4;
  assign jump_tgt   = {i_jump_target[31:2], 2'b00};
  assign branch_tgt = {i_branch_target[31:2], 2'b00};

`ifdef FETCH_IRQ_EN
  // Interrupt only from user mode and never while the pipeline is stalled.
  assign irq_take    = i_irq & ~pc_q[31] & ~i_stall;
  assign unused_bits = ^{i_jump_target[1:0], i_branch_target[1:0]};
`else
  assign irq_take    = 1'b0;
  assign unused_bits = ^{i_jump_target[1:0], i_branch_target[1:0], i_irq};
`endif

  // Non-interrupt next PC; also the return address captured on interrupt entry.
  always_comb begin
    norm_pc = pc_plus4;
    if (i_branch_taken)  norm_pc = branch_tgt;
    else if (i_stall)    norm_pc = pc_q;
    else if (i_jump)     norm_pc = jump_tgt;
  end

  // Next-state selection for PC, IF/ID and EPC.
  always_comb begin
    pc_d    = norm_pc;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    epc_d   = epc_q;
    if (irq_take) begin
      pc_d  = IRQ_VECTOR;
      epc_d = norm_pc;
    end
    if (i_branch_taken || irq_take || (!i_stall && i_jump)) begin
      instr_d = '0;
      pp4_d   = '0;
      valid_d = 1'b0;
    end else if (!i_stall) begin
      instr_d = i_imem_instruction;
      pp4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pp4_q   <= '0;
      valid_q <= 1'b0;
      epc_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
      epc_q   <= epc_d;
    end
  end

  assign o_imem_address     = pc_q[ADDR_W+1:2];
  assign o_pc               = pc_q;
  assign o_ifid_instruction = instr_q;
  assign o_ifid_pc_plus4    = pp4_q;
  assign o_ifid_valid       = valid_q;
`ifdef FETCH_IRQ_EN
  assign o_epc              = epc_q;
`else
  assign o_epc              = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized hazard traffic, compared against a behavioural fetch model.
// Interrupt scenarios are exercised when FETCH_IRQ_EN is defined.
module tb_instruction_fetch;

  localparam int unsigned AW = 9;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] IRQ_V  = 32'h8000_0004;

  logic          clk;
  logic          rst_n;
  logic          stall, jump, branch, irq;
  logic [31:0]   jt, bt;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_instruction;
  logic [31:0]   pc, ifid_instr, ifid_pp4, epc;
  logic          ifid_valid;

  logic [31:0] rom [0:(1<<AW)-1];

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_pp4, m_epc;
  logic        m_valid;

  int vectors;
  int miscompares;

  instruction_fetch #(.RESET_PC(RST_PC), .ADDR_W(AW), .IRQ_VECTOR(IRQ_V)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_stall            (stall),
    .i_jump             (jump),
    .i_jump_target      (jt),
    .i_branch_taken     (branch),
    .i_branch_target    (bt),
    .i_irq              (irq),
    .o_imem_address     (imem_address),
    .i_imem_instruction (imem_instruction),
    .o_pc               (pc),
    .o_ifid_instruction (ifid_instr),
    .o_ifid_pc_plus4    (ifid_pp4),
    .o_ifid_valid       (ifid_valid),
    .o_epc              (epc)
  );

  assign imem_instruction = rom[imem_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] exp_addr;
    exp_addr = {23'd0, m_pc[AW+1:2]};
    check({ctx, ".pc"},    pc, m_pc);
    check({ctx, ".addr"},  {23'd0, imem_address}, exp_addr);
    check({ctx, ".instr"}, ifid_instr, m_instr);
    check({ctx, ".pp4"},   ifid_pp4, m_pp4);
    check({ctx, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
    check({ctx, ".epc"},   epc, m_epc);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_pp4 = 0; m_valid = 0; m_epc = 0;
  endtask

  // One clock edge of the fetch stage, expressed directly from the priority rules.
  task automatic model_edge();
    logic [31:0] seq, other;
    logic        take_irq;
    seq = m_pc + 32'd4;
    if (branch)     other = bt & 32'hFFFF_FFFC;
    else if (stall) other = m_pc;
    else if (jump)  other = jt & 32'hFFFF_FFFC;
    else            other = seq;
`ifdef FETCH_IRQ_EN
    take_irq = irq && !m_pc[31] && !stall;
`else
    take_irq = 1'b0;
`endif
    if (take_irq || branch || (!stall && jump)) begin
      m_instr = 0; m_pp4 = 0; m_valid = 0;
    end else if (!stall) begin
      m_instr = rom[m_pc[AW+1:2]]; m_pp4 = seq; m_valid = 1;
    end
    if (take_irq) begin
      m_epc = other;
      m_pc  = IRQ_V;
    end else begin
      m_pc = other;
    end
  endtask

  task automatic step(input string ctx, input logic s, input logic j, input logic [31:0] jtv,
                      input logic b, input logic [31:0] btv, input logic q);
    stall = s; jump = j; jt = jtv; branch = b; bt = btv; irq = q;
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int unsigned i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rst_n = 1'b0;
    stall = 0; jump = 0; branch = 0; irq = 0; jt = 0; bt = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Sequential fetch from reset.
    for (int i = 0; i < 4; i++) idle("seq");

    // Three-cycle stall at 0x10, then resume.
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle("resume");
    idle("resume");

    // Reach 0x20, jump to 0x104.
    idle("seq2");
    idle("seq2");
    step("jump", 1'b0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
    idle("jump_after");

    // Branch beats stall and jump.
    step("br_prio", 1'b1, 1'b1, 32'h40, 1'b1, 32'h8, 1'b0);
    idle("br_after");

    // Target low bits forced to zero; PC wrap at the top of the address space.
    step("jmask", 1'b0, 1'b1, 32'h107, 1'b0, 32'h0, 1'b0);
    step("bmask", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0203, 1'b0);
    step("jwrap", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
    idle("wrap");
    idle("wrap2");

    // Asynchronous reset between edges while a jump is pending.
    stall = 0; branch = 0; irq = 0; jump = 1; jt = 32'h200;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(posedge clk);
    #1;
    check_all("midrst_hold");
    #3;
    rst_n = 1'b1;
    jump = 0;
    idle("post_rst");

`ifdef FETCH_IRQ_EN
    step("to30", 1'b0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
    step("irq", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("irq_kern", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("irq_kern2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("to40", 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    step("irq_br", 1'b0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b1);
    step("irq_stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("ret", 1'b0, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0);
    step("irq_jmp", 1'b0, 1'b1, 32'h124, 1'b0, 32'h0, 1'b1);
    step("ret2", 1'b0, 1'b1, 32'h70, 1'b0, 32'h0, 1'b0);
`endif

    // Randomized hazard traffic.
    for (int n = 0; n < 300; n++) begin
      logic s, j, b, q;
      logic [31:0] jtv, btv;
      s   = ($urandom_range(0, 99) < 30);
      j   = ($urandom_range(0, 99) < 20);
      b   = ($urandom_range(0, 99) < 15);
      q   = ($urandom_range(0, 99) < 10);
      jtv = ($urandom_range(0, 7) == 0) ? $urandom : {20'd0, $urandom_range(0, 4095)};
      btv = ($urandom_range(0, 7) == 0) ? $urandom : {20'd0, $urandom_range(0, 4095)};
      if (($urandom_range(0, 15) == 0) && pc[31]) begin
        j = 1'b1; b = 1'b0; s = 1'b0; jtv = {20'd0, $urandom_range(0, 4095)};
      end
      step("rand", s, j, jtv, b, btv, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
